// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port, word-addressed data memory between the
// pipeline MEM stage (byte/half/word loads and stores) and a word-only debug
// port. Sub-word stores become a read-modify-write through the hold register.
// Optional feature macro: DMEM_ARB_RR_EN. When it is defined, contention is
// settled round-robin using the last grant. When it is undefined, the pipeline
// has fixed priority.
module dmem_arbiter #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [1:0]        p_size,
    input  logic              p_unsigned,
    input  logic [31:0]       p_addr,
    input  logic [31:0]       p_wdata,
    output logic              p_gnt,
    output logic              p_err,
    output logic [31:0]       p_rdata,
    output logic              p_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic [31:0]       d_rdata,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_we,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata
);

    typedef enum logic {IDLE, RMW} state_t;

    state_t              state, state_nx;
    logic [31:0]         hold, hold_nx;
    logic                pick_p;
    logic                gnt_p, gnt_d, err_p;
    logic [31:0]         rdata_p, rdata_d, wdata_m;
    logic [ADDR_W-1:0]   addr_m;
    logic                we_m;
    logic [ADDR_W-1:0]   p_word, d_word;
    logic                unused_addr_bits;

    // Word addresses wrap: bits above the memory range are deliberately dropped.
    assign p_word = p_addr[ADDR_W+1:2];
    assign d_word = d_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{p_addr[31:ADDR_W+2], d_addr[31:ADDR_W+2], d_addr[1:0]};

    function automatic logic bad_access(input logic [1:0] size, input logic [1:0] lane);
        return (size == 2'b11) ||
               ((size == 2'b01) && lane[0]) ||
               ((size == 2'b10) && (lane != 2'b00));
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  lane,
                                                 input logic        uns);
        logic [31:0] shifted;
        logic [31:0] res;
        // Aligned halves have lane[0]=0, so a byte-lane shift also serves halves.
        shifted = word >> {lane, 3'b000};
        case (size)
            2'b00:   res = uns ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   res = uns ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane);
        logic [31:0] mask;
        logic [31:0] data;
        if (size == 2'b00) begin
            mask = 32'h0000_00FF << {lane, 3'b000};
            data = {24'd0, wdata[7:0]} << {lane, 3'b000};
        end else begin
            mask = 32'h0000_FFFF << {lane[1], 4'b0000};
            data = {16'd0, wdata[15:0]} << {lane[1], 4'b0000};
        end
        return (word & ~mask) | data;
    endfunction

`ifdef DMEM_ARB_RR_EN
    logic last;  // 1 = debug port received the most recent grant

    // Remember who was granted last so that contention alternates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (gnt_p) begin
            last <= 1'b0;
        end else if (gnt_d) begin
            last <= 1'b1;
        end
    end

    assign pick_p = p_req & (~d_req | last);
`else
    assign pick_p = p_req;
`endif

    // State and merged-store hold register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            hold  <= 32'd0;
        end else begin
            state <= state_nx;
            hold  <= hold_nx;
        end
    end

    // Owner selection, memory steering and grant generation.
    always_comb begin
        state_nx = state;
        hold_nx  = hold;
        gnt_p    = 1'b0;
        gnt_d    = 1'b0;
        err_p    = 1'b0;
        rdata_p  = 32'd0;
        rdata_d  = 32'd0;
        addr_m   = '0;
        we_m     = 1'b0;
        wdata_m  = 32'd0;
        case (state)
            IDLE: begin
                if (pick_p) begin
                    addr_m = p_word;
                    if (bad_access(p_size, p_addr[1:0])) begin
                        gnt_p = 1'b1;
                        err_p = 1'b1;
                    end else if (p_we && (p_size != 2'b10)) begin
                        hold_nx  = store_merge(m_rdata, p_wdata, p_size, p_addr[1:0]);
                        state_nx = RMW;
                    end else if (p_we) begin
                        gnt_p   = 1'b1;
                        we_m    = 1'b1;
                        wdata_m = p_wdata;
                    end else begin
                        gnt_p   = 1'b1;
                        rdata_p = load_extract(m_rdata, p_size, p_addr[1:0], p_unsigned);
                    end
                end else if (d_req) begin
                    addr_m = d_word;
                    gnt_d  = 1'b1;
                    if (d_we) begin
                        we_m    = 1'b1;
                        wdata_m = d_wdata;
                    end else begin
                        rdata_d = m_rdata;
                    end
                end
            end
            RMW: begin
                addr_m   = p_word;
                we_m     = 1'b1;
                wdata_m  = hold;
                gnt_p    = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Reset forces every output low, including a write in flight.
    assign p_gnt   = gnt_p & ~rst;
    assign p_err   = err_p & ~rst;
    assign p_rdata = rst ? 32'd0 : rdata_p;
    assign p_stall = p_req & ~gnt_p & ~rst;
    assign d_gnt   = gnt_d & ~rst;
    assign d_rdata = rst ? 32'd0 : rdata_d;
    assign m_addr  = rst ? '0 : addr_m;
    assign m_we    = we_m & ~rst;
    assign m_wdata = rst ? 32'd0 : wdata_m;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle vector table plus hand-written
// sequences for arbitration under contention and reset during a read-modify-write.
module tb_dmem_arbiter;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              p_req, p_we, p_unsigned;
    logic [1:0]        p_size;
    logic [31:0]       p_addr, p_wdata;
    logic              p_gnt, p_err, p_stall;
    logic [31:0]       p_rdata;
    logic              d_req, d_we;
    logic [31:0]       d_addr, d_wdata;
    logic              d_gnt;
    logic [31:0]       d_rdata;
    logic [ADDR_W-1:0] m_addr;
    logic              m_we;
    logic [31:0]       m_wdata, m_rdata;

    logic [31:0] mem [0:1023];
    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        p_req, p_we;
        logic [1:0]  p_size;
        logic        p_uns;
        logic [31:0] p_addr, p_wdata;
        logic        d_req, d_we;
        logic [31:0] d_addr, d_wdata;
        logic        e_pg, e_perr;
        logic [31:0] e_prd;
        logic        e_stall, e_dg;
        logic [31:0] e_drd;
        logic        e_mwe;
        logic [9:0]  e_maddr;
        logic [31:0] e_mwd;
    } vec_t;

    vec_t vecs [22];

    dmem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .p_req(p_req), .p_we(p_we), .p_size(p_size), .p_unsigned(p_unsigned),
        .p_addr(p_addr), .p_wdata(p_wdata),
        .p_gnt(p_gnt), .p_err(p_err), .p_rdata(p_rdata), .p_stall(p_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rdata(d_rdata),
        .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: synchronous write, combinational read, zero while writing.
    always @(posedge clk) if (m_we) mem[m_addr] <= m_wdata;
    assign m_rdata = m_we ? 32'd0 : mem[m_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        p_req = v.p_req; p_we = v.p_we; p_size = v.p_size; p_unsigned = v.p_uns;
        p_addr = v.p_addr; p_wdata = v.p_wdata;
        d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
    endtask

    task automatic idle_inputs();
        p_req = 1'b0; p_we = 1'b0; p_size = 2'b00; p_unsigned = 1'b0;
        p_addr = 32'd0; p_wdata = 32'd0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    endtask

    initial begin
        int pn, dn, ng, cyc;
        logic order [8];
        logic exp_order [8];

        //          preq  pwe   psz    uns   paddr         pwdata        dreq  dwe   daddr         dwdata        pg    perr  prd           stall dg    drd           mwe   maddr   mwd
        vecs[0]  = '{1'b0,1'b0,2'b00,1'b0,32'h0,        32'h0,        1'b1,1'b1,32'h000000A0,32'h12345678,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h0,        1'b1,10'd40,32'h12345678};
        vecs[1]  = '{1'b0,1'b0,2'b00,1'b0,32'h0,        32'h0,        1'b1,1'b0,32'h000000A0,32'h0,        1'b0,1'b0,32'h0,        1'b0,1'b1,32'h12345678,1'b0,10'd40,32'h0};
        vecs[2]  = '{1'b1,1'b1,2'b00,1'b0,32'h000000A1,32'h000000FF,1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,        1'b0,10'd40,32'h0};
        vecs[3]  = '{1'b1,1'b1,2'b00,1'b0,32'h000000A1,32'h000000FF,1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b1,10'd40,32'h1234FF78};
        vecs[4]  = '{1'b1,1'b0,2'b00,1'b0,32'h000000A1,32'h0,        1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b0,32'hFFFFFFFF,1'b0,1'b0,32'h0,        1'b0,10'd40,32'h0};
        vecs[5]  = '{1'b1,1'b0,2'b00,1'b1,32'h000000A1,32'h0,        1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b0,32'h000000FF,1'b0,1'b0,32'h0,        1'b0,10'd40,32'h0};
        vecs[6]  = '{1'b1,1'b0,2'b01,1'b0,32'h000000A2,32'h0,        1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b0,32'h00001234,1'b0,1'b0,32'h0,        1'b0,10'd40,32'h0};
        vecs[7]  = '{1'b1,1'b0,2'b01,1'b0,32'h000000A1,32'h0,        1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b1,32'h0,        1'b0,1'b0,32'h0,        1'b0,10'd40,32'h0};
        vecs[8]  = '{1'b1,1'b0,2'b10,1'b0,32'h000000A0,32'h0,        1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b0,32'h1234FF78,1'b0,1'b0,32'h0,        1'b0,10'd40,32'h0};
        vecs[9]  = '{1'b1,1'b1,2'b10,1'b0,32'h000000A2,32'hDEADBEEF,1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b1,32'h0,        1'b0,1'b0,32'h0,        1'b0,10'd40,32'h0};
        vecs[10] = '{1'b1,1'b0,2'b10,1'b0,32'h000000A0,32'h0,        1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b0,32'h1234FF78,1'b0,1'b0,32'h0,        1'b0,10'd40,32'h0};
        vecs[11] = '{1'b1,1'b0,2'b11,1'b0,32'h000000A0,32'h0,        1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b1,32'h0,        1'b0,1'b0,32'h0,        1'b0,10'd40,32'h0};
        vecs[12] = '{1'b1,1'b1,2'b01,1'b0,32'h000000A2,32'h0000ABCD,1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,        1'b0,10'd40,32'h0};
        vecs[13] = '{1'b1,1'b1,2'b01,1'b0,32'h000000A2,32'h0000ABCD,1'b1,1'b0,32'h000000A0,32'h0,        1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b1,10'd40,32'hABCDFF78};
        vecs[14] = '{1'b0,1'b0,2'b00,1'b0,32'h0,        32'h0,        1'b1,1'b0,32'h000000A0,32'h0,        1'b0,1'b0,32'h0,        1'b0,1'b1,32'hABCDFF78,1'b0,10'd40,32'h0};
        vecs[15] = '{1'b0,1'b0,2'b00,1'b0,32'h0,        32'h0,        1'b1,1'b1,32'h000010A3,32'h0BADF00D,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h0,        1'b1,10'd40,32'h0BADF00D};
        vecs[16] = '{1'b1,1'b0,2'b10,1'b0,32'h000000A0,32'h0,        1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b0,32'h0BADF00D,1'b0,1'b0,32'h0,        1'b0,10'd40,32'h0};
        vecs[17] = '{1'b1,1'b1,2'b10,1'b0,32'h000000A4,32'h00018001,1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b1,10'd41,32'h00018001};
        vecs[18] = '{1'b1,1'b0,2'b01,1'b0,32'h000000A4,32'h0,        1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b0,32'hFFFF8001,1'b0,1'b0,32'h0,        1'b0,10'd41,32'h0};
        vecs[19] = '{1'b1,1'b0,2'b01,1'b1,32'h000000A6,32'h0,        1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b0,32'h00000001,1'b0,1'b0,32'h0,        1'b0,10'd41,32'h0};
        vecs[20] = '{1'b1,1'b0,2'b00,1'b0,32'h000000A5,32'h0,        1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b0,32'hFFFFFF80,1'b0,1'b0,32'h0,        1'b0,10'd41,32'h0};
        vecs[21] = '{1'b0,1'b0,2'b00,1'b0,32'h0,        32'h0,        1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,10'd0, 32'h0};

        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;

        // Reset with every request asserted: all outputs must stay low.
        rst = 1'b1;
        p_req = 1'b1; p_we = 1'b1; p_size = 2'b10; p_unsigned = 1'b0;
        p_addr = 32'h000000A0; p_wdata = 32'hCAFEBABE;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h000000A0; d_wdata = 32'h11111111;
        #1;
        chk("rst p_gnt",   32'(p_gnt),   32'd0);
        chk("rst d_gnt",   32'(d_gnt),   32'd0);
        chk("rst m_we",    32'(m_we),    32'd0);
        chk("rst p_stall", 32'(p_stall), 32'd0);
        chk("rst m_addr",  32'(m_addr),  32'd0);
        chk("rst m_wdata", m_wdata,      32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();

        // Table: one vector per clock cycle, checked mid-cycle.
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("row%0d p_gnt", i),   32'(p_gnt),   32'(vecs[i].e_pg));
            chk($sformatf("row%0d p_err", i),   32'(p_err),   32'(vecs[i].e_perr));
            chk($sformatf("row%0d p_rdata", i), p_rdata,      vecs[i].e_prd);
            chk($sformatf("row%0d p_stall", i), 32'(p_stall), 32'(vecs[i].e_stall));
            chk($sformatf("row%0d d_gnt", i),   32'(d_gnt),   32'(vecs[i].e_dg));
            chk($sformatf("row%0d d_rdata", i), d_rdata,      vecs[i].e_drd);
            chk($sformatf("row%0d m_we", i),    32'(m_we),    32'(vecs[i].e_mwe));
            chk($sformatf("row%0d m_addr", i),  32'(m_addr),  32'(vecs[i].e_maddr));
            chk($sformatf("row%0d m_wdata", i), m_wdata,      vecs[i].e_mwd);
        end

        // Contention: both ports hold word reads until each has four grants.
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
`ifdef DMEM_ARB_RR_EN
        for (int k = 0; k < 8; k++) exp_order[k] = (k % 2 == 0);
`else
        for (int k = 0; k < 8; k++) exp_order[k] = (k < 4);
`endif
        pn = 0; dn = 0; ng = 0; cyc = 0;
        while ((pn < 4 || dn < 4) && cyc < 16) begin
            @(negedge clk);
            p_req = (pn < 4); p_we = 1'b0; p_size = 2'b10; p_addr = 32'h000000A0;
            d_req = (dn < 4); d_we = 1'b0; d_addr = 32'h000000A4;
            #1;
            chk($sformatf("arb cyc%0d grant count", cyc), 32'(p_gnt) + 32'(d_gnt), 32'd1);
            if (p_gnt) begin
                chk("arb p_rdata", p_rdata, 32'h0BADF00D);
                if (ng < 8) order[ng] = 1'b1;
                ng++; pn++;
            end else if (d_gnt) begin
                chk("arb d_rdata", d_rdata, 32'h00018001);
                if (ng < 8) order[ng] = 1'b0;
                ng++; dn++;
            end
            cyc++;
        end
        chk("arb total grants", 32'(ng), 32'd8);
        for (int k = 0; k < 8; k++)
            if (k < ng) chk($sformatf("arb order%0d is_pipe", k), 32'(order[k]), 32'(exp_order[k]));
        @(negedge clk);
        idle_inputs();

        // Reset pulse in the RMW cycle of an sb: write must be abandoned.
        @(negedge clk);
        p_req = 1'b1; p_we = 1'b1; p_size = 2'b00; p_addr = 32'h000000A0; p_wdata = 32'h00000055;
        #1;
        chk("rmwrst stall", 32'(p_stall), 32'd1);
        @(negedge clk);
        #1;
        chk("rmwrst m_we before", 32'(m_we), 32'd1);
        chk("rmwrst merged", m_wdata, 32'h0BADF055);
        #1 rst = 1'b1;
        #1;
        chk("rmwrst m_we during", 32'(m_we), 32'd0);
        chk("rmwrst p_gnt during", 32'(p_gnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        p_we = 1'b0; p_size = 2'b10; p_wdata = 32'd0;
        #1;
        chk("rmwrst idle gnt", 32'(p_gnt), 32'd1);
        chk("rmwrst word kept", p_rdata, 32'h0BADF00D);
        chk("rmwrst mem word", mem[40], 32'h0BADF00D);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
